// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: shifts a captured MSB-first bit pattern out as
// back-to-back frames, for a fixed frame count or continuously until stopped.
module seq_pattern_gen #(
  parameter int MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [3:0]         len,
  input  logic [3:0]         repeat_cnt,
  input  logic               stop,
  output logic               out_bit,
  output logic               out_valid,
  output logic               frame_start,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [4:0] LEN_LIMIT = 5'(MAX_LEN);

  logic [1:0]  state_q, state_d;
  logic [15:0] pat_q, pat_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  rep_q, rep_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic        stop_q, stop_d;
  logic        out_bit_q, out_bit_d;
  logic        out_valid_q, out_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [15:0] pattern_ext;
  logic        len_ok;
  logic        last_frame;

  // Zero-extend so a 4-bit index always addresses the pattern exactly.
  always_comb begin
    pattern_ext = '0;
    pattern_ext[MAX_LEN-1:0] = pattern;
  end

  assign len_ok = (len != 4'd0) && ({1'b0, len} <= LEN_LIMIT);

  // The counter may wrap in continuous mode; rep_q==0 keeps it from ending a run.
  assign last_frame = stop_q || stop ||
                      ((rep_q != 4'd0) && ((frame_cnt_q + 4'd1) == rep_q));

  always_comb begin
    state_d       = state_q;
    pat_d         = pat_q;
    len_d         = len_q;
    rep_d         = rep_q;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    stop_d        = stop_q;
    out_bit_d     = 1'b0;
    out_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        stop_d      = 1'b0;
        frame_cnt_d = 4'd0;
        if (start) begin
          if (len_ok) begin
            pat_d         = pattern_ext;
            len_d         = len;
            rep_d         = repeat_cnt;
            idx_d         = len - 4'd1;
            out_bit_d     = pattern_ext[len - 4'd1];
            out_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
            state_d       = S_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_SHIFT: begin
        stop_d      = stop_q || stop;
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
        if (idx_q == 4'd0) begin
          if (last_frame) begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_d      = 1'b0;
            state_d     = S_DONE;
          end else begin
            frame_cnt_d   = frame_cnt_q + 4'd1;
            idx_d         = len_q - 4'd1;
            out_bit_d     = pat_q[len_q - 4'd1];
            frame_start_d = 1'b1;
          end
        end else begin
          idx_d     = idx_q - 4'd1;
          out_bit_d = pat_q[idx_q - 4'd1];
        end
      end

      S_DONE: begin
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pat_q         <= '0;
      len_q         <= '0;
      rep_q         <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      stop_q        <= 1'b0;
      out_bit_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      len_q         <= len_d;
      rep_q         <= rep_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      stop_q        <= stop_d;
      out_bit_q     <= out_bit_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign out_bit     = out_bit_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter: MAX_LEN, default 8, the maximum pattern length in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 SHALL have port: start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-005 SHALL have port: pattern  input  MAX_LEN  bit pattern; bit len-1 is sent first.
REQ-006 SHALL have port: len  input  4  pattern length in bits; legal range 1..MAX_LEN.
REQ-007 SHALL have port: repeat_cnt  input  4  number of frames; 1..15, with 0 = continuous.
REQ-008 SHALL have port: stop  input  1  request to end the transmission after the current frame.
REQ-009 SHALL have port: out_bit  output  1  serial data bit, intended to feed the Mealy sequence detector in_bit.
REQ-010 SHALL have port: out_valid  output  1  out_bit carries pattern data this cycle.
REQ-011 SHALL have port: frame_start  output  1  high coincident with the first bit of each frame.
REQ-012 SHALL have port: busy  output  1  high in SHIFT.
REQ-013 SHALL have port: done  output  1  one-cycle pulse after the last bit.
REQ-014 SHALL have port: err  output  1  one-cycle pulse when start is rejected.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT and DONE; all outputs registered.
REQ-016 IDLE with start=1 and 1<=len<=MAX_LEN SHALL capture pattern, len and repeat_cnt, then go to SHIFT; the first bit SHALL appear on the next cycle (latency 1).
REQ-017 IDLE with start=1 and len=0 or len>MAX_LEN SHALL pulse err for 1 cycle and stay in IDLE.
REQ-018 In SHIFT, the block SHALL send one bit per cycle, in order pattern[len-1] down to pattern[0].
REQ-019 In SHIFT, out_valid and busy SHALL be 1, and frame_start SHALL be 1 only on bit pattern[len-1].
REQ-020 Changes to pattern, len or repeat_cnt during SHIFT SHALL be ignored; the captured copies govern.
REQ-021 Frames SHALL be sent back-to-back with no gap cycle; bit 0 of frame k is followed directly by bit len-1 of frame k+1.
REQ-022 After the last bit of frame repeat_cnt (repeat_cnt!=0), the FSM SHALL go to DONE: done=1, out_valid=0, busy=0, out_bit=0 for 1 cycle, then IDLE.
REQ-023 With repeat_cnt=0, frames SHALL repeat indefinitely until stop.
REQ-024 stop=1 in SHIFT SHALL be latched (sticky); the current frame SHALL complete, then DONE. stop on the last bit of a frame SHALL end after that frame.
REQ-025 stop in IDLE or DONE SHALL be ignored and not latched.
REQ-026 start in SHIFT or DONE SHALL be ignored; no err.
REQ-027 len=1 SHALL produce a 1-cycle frame, with frame_start=1 every SHIFT cycle.
REQ-028 The internal frame counter SHALL be 4 bits wide; with repeat_cnt=0 it SHALL not stop on wrap-around (it saturates or is unused).
REQ-029 In IDLE and DONE, out_bit SHALL be 0 and out_valid SHALL be 0.

Reset
REQ-030 On a rising edge with reset=0, the FSM SHALL go to IDLE, clear all outputs to 0, and clear the stop latch and counters, regardless of state.
REQ-031 reset=0 SHALL take priority over start and stop in the same cycle.
REQ-032 Reset mid-SHIFT SHALL abort the frame immediately with no done pulse; the next start SHALL behave as from power-up.

Verification
REQ-033 pattern=8'b0000_1011, len=4, repeat_cnt=1, start pulse -> out_bit 1,0,1,1 with out_valid=1 over 4 cycles starting 1 cycle after start, frame_start on the first bit, done at cycle 5; a connected Mealy_1011 detector SHALL assert out once.
REQ-034 pattern=4'b101, len=3, repeat_cnt=3 -> 9 contiguous valid bits 101101101, frame_start at bits 1, 4 and 7, a single done pulse.
REQ-035 repeat_cnt=0, len=4, pattern=1011; stop asserted on bit 2 of frame 3 -> frame 3 completes, done follows, and exactly 12 valid bits are sent.
REQ-036 start with len=0, then with len=9 (MAX_LEN=8) -> err pulse each time, busy stays 0, out_valid stays 0.
REQ-037 reset=0 asserted on bit 2 of a 4-bit frame -> next cycle all outputs 0 with no done; a new start after reset=1 sends the full pattern correctly.
REQ-038 start re-asserted mid-frame and pattern changed mid-frame -> no effect on the current transmission.
